// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC memory responder: op3 codes, FSM states,
// request decode and alignment masks.
package sparc_mem_pkg;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_STD  = 6'b000111;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  localparam logic [2:0] ALIGN_MASK_HALF = 3'b001;
  localparam logic [2:0] ALIGN_MASK_WORD = 3'b011;
  localparam logic [2:0] ALIGN_MASK_DBL  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_XFER = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic       sign_ext;
    logic       dbl;
    logic [2:0] nbytes;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t info;
    info.valid    = 1'b1;
    info.is_load  = 1'b1;
    info.sign_ext = 1'b0;
    info.dbl      = 1'b0;
    info.nbytes   = 3'd4;
    case (op)
      OP_LD:   info.nbytes = 3'd4;
      OP_LDUB: info.nbytes = 3'd1;
      OP_LDUH: info.nbytes = 3'd2;
      OP_LDD:  info.dbl = 1'b1;
      OP_ST:   info.is_load = 1'b0;
      OP_STB:  begin info.is_load = 1'b0; info.nbytes = 3'd1; end
      OP_STH:  begin info.is_load = 1'b0; info.nbytes = 3'd2; end
      OP_STD:  begin info.is_load = 1'b0; info.dbl = 1'b1; end
      OP_LDSB: begin info.sign_ext = 1'b1; info.nbytes = 3'd1; end
      OP_LDSH: begin info.sign_ext = 1'b1; info.nbytes = 3'd2; end
      default: info.valid = 1'b0;
    endcase
    return info;
  endfunction

  // Address bits that must be zero for a naturally aligned access of this kind.
  function automatic logic [2:0] align_mask(input op_info_t info);
    logic [2:0] mask;
    if (info.dbl) begin
      mask = ALIGN_MASK_DBL;
    end else if (info.nbytes == 3'd4) begin
      mask = ALIGN_MASK_WORD;
    end else if (info.nbytes == 3'd2) begin
      mask = ALIGN_MASK_HALF;
    end else begin
      mask = 3'b000;
    end
    return mask;
  endfunction

endpackage

// File: rtl/mem_array_512x8.sv
// Byte array with synchronous write and combinational read; contents are
// never reset.
module mem_array_512x8 #(
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];

  // Single byte write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sparc_mem_responder.sv
// Multi-cycle big-endian byte-serial memory target for the SPARC MAR/MDR port.
// Define MEM_ALIGN_CHECK_EN to reject misaligned halfword/word/doubleword accesses.
module sparc_mem_responder
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        MFC,
  output logic        MSET
);

  localparam logic [3:0] LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e              state_q, state_d;
  op_info_t            op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                err_q, err_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic [31:0]         dout_q, dout_d;
  logic                mfc_q, mfc_d;
  logic                mset_q, mset_d;

  op_info_t            info_s;
  logic                range_err_s;
  logic                align_err_s;
  logic [2:0]          nbm1_s;
  logic [1:0]          last_idx_s;
  logic [1:0]          byte_idx_s;
  logic [31:0]         shifted_s;
  logic [31:0]         word_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic                mem_we_s;
  logic [7:0]          mem_wdata_s;
  logic [7:0]          mem_rdata_s;

  mem_array_512x8 #(.ADDR_W(ADDR_W)) u_mem (
    .clk_i   (Clk),
    .we_i    (mem_we_s),
    .addr_i  (mem_addr_s),
    .wdata_i (mem_wdata_s),
    .rdata_o (mem_rdata_s)
  );

  assign info_s      = decode_op(RAM_OpCode);
  assign range_err_s = |Address[31:ADDR_W];

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err_s = |(Address[2:0] & align_mask(info_s));
`else
  assign align_err_s = 1'b0;
`endif

  // Byte k of an n-byte access carries data byte n-1-k (big-endian), at a wrapping address.
  assign nbm1_s      = op_q.nbytes - 3'd1;
  assign last_idx_s  = nbm1_s[1:0];
  assign byte_idx_s  = last_idx_s - byte_cnt_q;
  assign shifted_s   = data_q >> {byte_idx_s, 3'b000};
  assign mem_wdata_s = shifted_s[7:0];
  assign mem_addr_s  = addr_q + ADDR_W'(byte_cnt_q);
  assign word_s      = {asm_q, mem_rdata_s};

  // Next-state, capture, transfer and extension logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    dout_d     = dout_q;
    mem_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RAM_enable) begin
          op_d       = info_s;
          addr_d     = Address[ADDR_W-1:0];
          data_d     = Data_In;
          err_d      = !info_s.valid || range_err_s || align_err_s;
          wait_cnt_d = 4'd0;
          byte_cnt_d = 2'd0;
          asm_d      = 24'h000000;
          state_d    = (LATENCY == 0) ? ST_XFER : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (err_q) begin
          state_d = ST_ERR;
        end else if (wait_cnt_q == LAT_LAST) begin
          state_d = ST_XFER;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_XFER: begin
        // Rejected requests leave here before any byte is touched.
        if (err_q) begin
          state_d = ST_ERR;
        end else begin
          mem_we_s = !op_q.is_load;
          asm_d    = {asm_q[15:0], mem_rdata_s};
          if (byte_cnt_q == last_idx_s) begin
            state_d = ST_DONE;
            if (op_q.is_load) begin
              case (op_q.nbytes)
                3'd1: dout_d = op_q.sign_ext ? {{24{word_s[7]}}, word_s[7:0]}
                                             : {24'h000000, word_s[7:0]};
                3'd2: dout_d = op_q.sign_ext ? {{16{word_s[15]}}, word_s[15:0]}
                                             : {16'h0000, word_s[15:0]};
                default: dout_d = word_s;
              endcase
            end else begin
              dout_d = dout_q;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      ST_DONE, ST_ERR: begin
        if (!RAM_enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mfc_d  = (state_d == ST_DONE) || (state_d == ST_ERR);
    mset_d = (state_d == ST_ERR);
  end

  // State, capture and output registers.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= 32'h00000000;
      err_q      <= 1'b0;
      wait_cnt_q <= 4'd0;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'h000000;
      dout_q     <= 32'h00000000;
      mfc_q      <= 1'b0;
      mset_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      dout_q     <= dout_d;
      mfc_q      <= mfc_d;
      mset_q     <= mset_d;
    end
  end

  assign Data_Out = dout_q;
  assign MFC      = mfc_q;
  assign MSET     = mset_q;

endmodule
